// File: rtl/ccff_bitstream_loader.sv
// Streams a bitstream into the fabric configuration chains and can stream it a
// second time to read back the chain tails and count mismatched bits.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | pass 1: accepting words and shifting them into the chains
// DRAIN  | final pass-1 shift completes
// VERIFY | pass 2: accepting words, shifting, comparing chain tails
// VDRAIN | final pass-2 shift and compare complete
// DONE   | one-cycle done pulse, pass_ok updated
module ccff_bitstream_loader #(
    parameter int NUM_CHAINS = 12,
    parameter int CHAIN_LEN  = 1024,
    parameter int ERR_W      = 16
) (
    input  logic                  prog_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  verify_en,
    input  logic [NUM_CHAINS-1:0] bs_data,
    input  logic                  bs_valid,
    output logic                  bs_ready,
    output logic [NUM_CHAINS-1:0] ccff_head,
    input  logic [NUM_CHAINS-1:0] ccff_tail,
    output logic                  config_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  pass_ok,
    output logic [ERR_W-1:0]      err_count,
    output logic [NUM_CHAINS-1:0] err_chain
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int POP_W = $clog2(NUM_CHAINS + 1);
    localparam int SUM_W = ((ERR_W > POP_W) ? ERR_W : POP_W) + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_VERIFY = 3'd3;
    localparam logic [2:0] S_VDRAIN = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [CNT_W-1:0]      acc_cnt;
    logic                  verify_lat;
    logic                  hs;
    logic                  last_accept;
    logic                  cmp_en;
    logic [NUM_CHAINS-1:0] mismatch;
    logic [POP_W-1:0]      mis_pop;
    logic [SUM_W-1:0]      err_sum;
    logic [ERR_W-1:0]      err_nxt;

    assign bs_ready    = ((state == S_LOAD) || (state == S_VERIFY)) &&
                         (acc_cnt < CNT_W'(CHAIN_LEN));
    assign hs          = bs_valid & bs_ready;
    assign last_accept = hs && (acc_cnt == CNT_W'(CHAIN_LEN - 1));
    assign busy        = (state != S_IDLE);

    // The tail seen on a verify-pass shift is the pass-1 bit now falling out,
    // so it lines up with the head bit being shifted in on the same edge.
    assign cmp_en   = config_enable && ((state == S_VERIFY) || (state == S_VDRAIN));
    assign mismatch = cmp_en ? (ccff_tail ^ ccff_head) : '0;

    always_comb begin
        mis_pop = '0;
        for (int i = 0; i < NUM_CHAINS; i++) begin
            mis_pop = mis_pop + POP_W'(mismatch[i]);
        end
        err_sum = SUM_W'(err_count) + SUM_W'(mis_pop);
        err_nxt = (err_sum > SUM_W'({ERR_W{1'b1}})) ? '1 : err_sum[ERR_W-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LOAD;
            S_LOAD:   if (last_accept) state_nxt = S_DRAIN;
            S_DRAIN:  state_nxt = verify_lat ? S_VERIFY : S_DONE;
            S_VERIFY: if (last_accept) state_nxt = S_VDRAIN;
            S_VDRAIN: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            acc_cnt       <= '0;
            verify_lat    <= 1'b0;
            ccff_head     <= '0;
            config_enable <= 1'b0;
            done          <= 1'b0;
            pass_ok       <= 1'b0;
            err_count     <= '0;
            err_chain     <= '0;
        end else begin
            state         <= state_nxt;
            config_enable <= hs;
            done          <= (state_nxt == S_DONE);
            if (hs) begin
                ccff_head <= bs_data;
                acc_cnt   <= acc_cnt + CNT_W'(1);
            end
            if (cmp_en) begin
                err_count <= err_nxt;
                err_chain <= err_chain | mismatch;
            end
            if (state == S_DRAIN) begin
                acc_cnt <= '0;
            end
            // err_nxt already folds in the compare happening on this edge
            if (state_nxt == S_DONE) begin
                pass_ok <= (err_nxt == '0);
            end
            if ((state == S_IDLE) && start) begin
                verify_lat <= verify_en;
                acc_cnt    <= '0;
                err_count  <= '0;
                err_chain  <= '0;
                pass_ok    <= 1'b0;
            end
        end
    end

endmodule
